people_counter: RTL and testbench
=================================

Name: people_counter

Overview:
Upstream occupancy tracker for the bank queue manager.
- Inputs: entry (front door) and exit (back door) photocell sensors.
- Synchronises and debounces each sensor, then keeps a saturating 3-bit count of customers in the queue.
- PeopleCount feeds the wait-time lookup directly; Full/Empty drive the door and display logic.

Parameters:
COUNT_WIDTH, 3, width of PeopleCount; must match the wait-time lookup address field.
MAX_COUNT, 7, saturation value (queue capacity); must be at most 2^COUNT_WIDTH-1.
DEBOUNCE_CYCLES, 4, consecutive clock edges a synchronised sensor level must hold before it is accepted (range 1..2^DB_WIDTH-1).
DB_WIDTH, 3, width of each debounce counter.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
FrontSensor  input  1  raw entry photocell; 1 = beam broken; asynchronous to clk.
BackSensor  input  1  raw exit photocell; 1 = beam broken; asynchronous to clk.
PeopleCount  output  COUNT_WIDTH  registered customer count.
EmptyFlag  output  1  1 when PeopleCount == 0.
FullFlag  output  1  1 when PeopleCount == MAX_COUNT.
OverflowErr  output  1  one-cycle pulse when an entry is rejected because the queue is full.
UnderflowErr  output  1  one-cycle pulse when an exit is rejected because the queue is empty.

Behaviour:
- Reset (async assert, applies immediately):
  - PeopleCount = 0, EmptyFlag = 1, FullFlag = 0, OverflowErr = 0, UnderflowErr = 0.
  - All synchroniser flops, debounce counters and stable levels = 0.
  - Reset mid-debounce or mid-count discards any partial event; no event is generated on release.
- Synchroniser: each sensor passes through a 2-flop synchroniser (sync1, sync2).
- Debounce (per channel):
  - Stable level register S and counter D.
  - Each edge, if sync2 == S: D <= 0.
  - Else if D == DEBOUNCE_CYCLES-1: S <= sync2 and D <= 0.
  - Else: D <= D+1.
  - Any return to S before acceptance clears D; glitches shorter than DEBOUNCE_CYCLES synchronised cycles are ignored.
- Event definition:
  - Enter event = front S transitions 0->1.
  - Exit event = back S transitions 0->1.
  - 1->0 transitions generate nothing.
  - A held-high sensor produces exactly one event.
- Count update happens on the same edge at which S flips 0->1:
  - Enter only, count < MAX_COUNT: count+1.
  - Enter only, count == MAX_COUNT: count unchanged; OverflowErr = 1 for that cycle.
  - Exit only, count > 0: count-1.
  - Exit only, count == 0: count unchanged; UnderflowErr = 1 for that cycle.
  - Enter and exit on the same edge: count unchanged, no error pulse, at any count value including 0 and MAX_COUNT.
- Latency:
  - Raw sensor rising before edge 1 gives sync2 = 1 after edge 2.
  - Mismatch is counted at edges 3..(2+DEBOUNCE_CYCLES).
  - PeopleCount changes on edge 2+DEBOUNCE_CYCLES (edge 6 by default).
- Flags:
  - EmptyFlag and FullFlag decode the PeopleCount register, so they change in the same cycle as the count.
  - Error pulses are registered and last exactly one cycle.
- Arithmetic: never wraps; the count stays within 0..MAX_COUNT at all times.

Test Plan:
- Reset, then release; hold both sensors 0 for 20 cycles -> PeopleCount = 0, EmptyFlag = 1, FullFlag = 0, no error pulses.
- FrontSensor high for 10 cycles, then low -> PeopleCount goes 0->1 exactly 6 edges after the rise; EmptyFlag drops the same cycle; no further change when the sensor falls.
- FrontSensor high for 3 cycles (glitch), then low -> PeopleCount stays 0; front D returns to 0.
- Seven clean entries -> PeopleCount = 7, FullFlag = 1; 8th entry -> count stays 7, OverflowErr high for exactly 1 cycle; one exit -> count 6, FullFlag = 0.
- From count 0, one clean exit -> count stays 0, UnderflowErr pulses once.
- Simultaneous entry and exit:
  - At count 3, both sensors rise on the same cycle -> count stays 3, no error pulse.
  - Repeat at count 0 and at count 7 -> unchanged, no error pulse.
- Reset mid-operation: at count 5, assert rst while FrontSensor is mid-debounce (D = 2) -> outputs return to reset values immediately; after release with FrontSensor still high, one entry is counted (count = 1) after the full latency.

Source files
------------

// File: rtl/people_counter.sv
// Queue occupancy tracker: synchronises and debounces the entry/exit photocells,
// then keeps a saturating customer count with full/empty flags and error pulses.
module people_counter #(
  parameter int COUNT_WIDTH     = 3,
  parameter int MAX_COUNT       = 7,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_WIDTH        = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   FrontSensor,
  input  logic                   BackSensor,
  output logic [COUNT_WIDTH-1:0] PeopleCount,
  output logic                   EmptyFlag,
  output logic                   FullFlag,
  output logic                   OverflowErr,
  output logic                   UnderflowErr
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = COUNT_WIDTH'(MAX_COUNT);
  localparam logic [DB_WIDTH-1:0]    DB_ZERO  = {DB_WIDTH{1'b0}};
  localparam logic [DB_WIDTH-1:0]    DB_ONE   = DB_WIDTH'(1);
  localparam logic [DB_WIDTH-1:0]    DB_LAST  = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Channel 0 is the front (entry) door, channel 1 the back (exit) door.
  logic [1:0]               raw_s;
  logic [1:0]               sync1_r;
  logic [1:0]               sync2_r;
  logic [1:0]               stable_r;
  logic [1:0]               stable_nxt_s;
  logic [1:0]               rise_s;
  logic [1:0][DB_WIDTH-1:0] db_cnt_r;
  logic [1:0][DB_WIDTH-1:0] db_cnt_nxt_s;
  logic [COUNT_WIDTH-1:0]   cnt_nxt_s;
  logic                     ovf_nxt_s;
  logic                     udf_nxt_s;

  assign raw_s = {BackSensor, FrontSensor};

  // Two-flop synchronisers for both asynchronous photocells.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    stable_nxt_s = stable_r;
    db_cnt_nxt_s = db_cnt_r;
    rise_s       = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      if (sync2_r[ch] == stable_r[ch]) begin
        db_cnt_nxt_s[ch] = DB_ZERO;
      end else if (db_cnt_r[ch] == DB_LAST) begin
        stable_nxt_s[ch] = sync2_r[ch];
        db_cnt_nxt_s[ch] = DB_ZERO;
      end else begin
        db_cnt_nxt_s[ch] = db_cnt_r[ch] + DB_ONE;
      end
      rise_s[ch] = ~stable_r[ch] & stable_nxt_s[ch];
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_r <= 2'b00;
      db_cnt_r <= {2{DB_ZERO}};
    end else begin
      stable_r <= stable_nxt_s;
      db_cnt_r <= db_cnt_nxt_s;
    end
  end

  // Saturating count update; simultaneous entry and exit cancel out silently.
  always_comb begin
    cnt_nxt_s = PeopleCount;
    ovf_nxt_s = 1'b0;
    udf_nxt_s = 1'b0;
    case (rise_s)
      2'b01: begin
        if (PeopleCount < CNT_MAX) begin
          cnt_nxt_s = PeopleCount + CNT_ONE;
        end else begin
          ovf_nxt_s = 1'b1;
        end
      end
      2'b10: begin
        if (PeopleCount != CNT_ZERO) begin
          cnt_nxt_s = PeopleCount - CNT_ONE;
        end else begin
          udf_nxt_s = 1'b1;
        end
      end
      default: begin
        cnt_nxt_s = PeopleCount;
      end
    endcase
  end

  // Flags are registered from the next count so they move with PeopleCount.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PeopleCount  <= CNT_ZERO;
      EmptyFlag    <= 1'b1;
      FullFlag     <= 1'b0;
      OverflowErr  <= 1'b0;
      UnderflowErr <= 1'b0;
    end else begin
      PeopleCount  <= cnt_nxt_s;
      EmptyFlag    <= (cnt_nxt_s == CNT_ZERO);
      FullFlag     <= (cnt_nxt_s == CNT_MAX);
      OverflowErr  <= ovf_nxt_s;
      UnderflowErr <= udf_nxt_s;
    end
  end

endmodule

// File: tb/tb_people_counter.sv
// Self-checking bench for people_counter: table-driven segments, hand-written
// latency/reset sequences and randomized sensor traffic against a window-based model.
module tb_people_counter;

  localparam int CW  = 3;
  localparam int MAXC = 7;
  localparam int DBC = 4;
  localparam int HL  = DBC + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          FrontSensor = 1'b0;
  logic          BackSensor = 1'b0;
  logic [CW-1:0] PeopleCount;
  logic          EmptyFlag, FullFlag, OverflowErr, UnderflowErr;

  people_counter #(.COUNT_WIDTH(CW), .MAX_COUNT(MAXC), .DEBOUNCE_CYCLES(DBC), .DB_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .FrontSensor(FrontSensor), .BackSensor(BackSensor),
    .PeopleCount(PeopleCount), .EmptyFlag(EmptyFlag), .FullFlag(FullFlag),
    .OverflowErr(OverflowErr), .UnderflowErr(UnderflowErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic f;
    logic b;
    int   n;
    int   cnt;
    int   ovf;
    int   udf;
  } vec_t;

  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;
  int   seg_ovf, seg_udf;

  // Reference model: raw samples per edge; a door's accepted level flips once the
  // samples taken 2..DBC+1 edges ago all disagree with it.
  logic hf[HL], hb[HL];
  logic sf, sb;
  int   mcnt;
  logic movf, mudf;

  task automatic model_reset();
    for (int i = 0; i < HL; i++) begin hf[i] = 1'b0; hb[i] = 1'b0; end
    sf = 1'b0; sb = 1'b0; mcnt = 0; movf = 1'b0; mudf = 1'b0;
  endtask

  task automatic model_edge(input logic f, input logic b);
    logic ff, fb, ent, ext;
    for (int i = HL - 1; i > 0; i--) begin hf[i] = hf[i-1]; hb[i] = hb[i-1]; end
    hf[0] = f; hb[0] = b;
    ff = 1'b1; fb = 1'b1;
    for (int i = 2; i < HL; i++) begin
      if (hf[i] == sf) ff = 1'b0;
      if (hb[i] == sb) fb = 1'b0;
    end
    ent = ff && !sf;
    ext = fb && !sb;
    if (ff) sf = !sf;
    if (fb) sb = !sb;
    movf = 1'b0; mudf = 1'b0;
    if (ent && !ext) begin
      if (mcnt < MAXC) mcnt++; else movf = 1'b1;
    end else if (ext && !ent) begin
      if (mcnt > 0) mcnt--; else mudf = 1'b1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, compare all outputs after the edge.
  task automatic step(input logic f, input logic b);
    logic [CW+3:0] act, exp;
    FrontSensor = f;
    BackSensor  = b;
    @(posedge clk);
    model_edge(f, b);
    #1;
    act = {PeopleCount, EmptyFlag, FullFlag, OverflowErr, UnderflowErr};
    exp = {CW'(mcnt), (mcnt == 0), (mcnt == MAXC), movf, mudf};
    check("cycle", int'(act), int'(exp));
    if (OverflowErr) seg_ovf++;
    if (UnderflowErr) seg_udf++;
  endtask

  task automatic add(input logic f, input logic b, input int n, input int cnt,
                     input int ovf, input int udf);
    vec_t v;
    v.f = f; v.b = b; v.n = n; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
    tbl.push_back(v);
  endtask

  task automatic pulse_door(input logic f, input logic b, input int cnt, input int ovf, input int udf);
    add(f, b, 8, cnt, ovf, udf);
    add(1'b0, 1'b0, 8, cnt, 0, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, int'({PeopleCount, EmptyFlag, FullFlag, OverflowErr, UnderflowErr}),
          int'({CW'(0), 1'b1, 1'b0, 1'b0, 1'b0}));
  endtask

  initial begin
    // Segment table walking through every counting corner.
    add(1'b0, 1'b0, 20, 0, 0, 0);
    add(1'b1, 1'b0, 10, 1, 0, 0);
    add(1'b0, 1'b0, 10, 1, 0, 0);
    add(1'b1, 1'b0, 3, 1, 0, 0);
    add(1'b0, 1'b0, 10, 1, 0, 0);
    for (int k = 2; k <= 7; k++) pulse_door(1'b1, 1'b0, k, 0, 0);
    pulse_door(1'b1, 1'b0, 7, 1, 0);
    for (int k = 6; k >= 3; k--) pulse_door(1'b0, 1'b1, k, 0, 0);
    pulse_door(1'b1, 1'b1, 3, 0, 0);
    for (int k = 2; k >= 0; k--) pulse_door(1'b0, 1'b1, k, 0, 0);
    pulse_door(1'b0, 1'b1, 0, 0, 1);
    pulse_door(1'b1, 1'b1, 0, 0, 0);
    for (int k = 1; k <= 7; k++) pulse_door(1'b1, 1'b0, k, 0, 0);
    pulse_door(1'b1, 1'b1, 7, 0, 0);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst = 1'b0;

    foreach (tbl[i]) begin
      seg_ovf = 0; seg_udf = 0;
      for (int c = 0; c < tbl[i].n; c++) step(tbl[i].f, tbl[i].b);
      check($sformatf("seg%0d_count", i), int'(PeopleCount), tbl[i].cnt);
      check($sformatf("seg%0d_flags", i), int'({EmptyFlag, FullFlag}),
            int'({tbl[i].cnt == 0, tbl[i].cnt == MAXC}));
      check($sformatf("seg%0d_ovf", i), seg_ovf, tbl[i].ovf);
      check($sformatf("seg%0d_udf", i), seg_udf, tbl[i].udf);
    end

    // Exact latency from a clean reset: count moves on the sixth edge.
    rst = 1'b1;
    #2;
    model_reset();
    check_reset_outputs("latency_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) step(1'b1, 1'b0);
    check("latency_edge5", int'({PeopleCount, EmptyFlag}), int'({CW'(0), 1'b1}));
    step(1'b1, 1'b0);
    check("latency_edge6", int'({PeopleCount, EmptyFlag}), int'({CW'(1), 1'b0}));
    repeat (10) step(1'b0, 1'b0);
    check("latency_fall", int'(PeopleCount), 1);

    // Reach count 5, then reset while the front door is mid-debounce.
    for (int k = 0; k < 4; k++) begin
      repeat (8) step(1'b1, 1'b0);
      repeat (8) step(1'b0, 1'b0);
    end
    check("pre_reset_count", int'(PeopleCount), 5);
    repeat (4) step(1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midop_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) step(1'b1, 1'b0);
    check("post_reset_edge5", int'(PeopleCount), 0);
    step(1'b1, 1'b0);
    check("post_reset_edge6", int'(PeopleCount), 1);
    repeat (10) step(1'b1, 1'b0);
    check("post_reset_held", int'(PeopleCount), 1);

    // Randomized traffic with glitches and overlapping door activity.
    for (int s = 0; s < 300; s++) begin
      logic rf, rb;
      int   n;
      rf = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      n  = int'($urandom_range(1, 12));
      for (int c = 0; c < n; c++) step(rf, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
